// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR engine: one signed MAC walks all TAPS+1 taps per accepted sample.
// Define FIR_SAT_EN to saturate DOUT; otherwise the scaled accumulator wraps to DATA_WIDTH bits.
module fir_mac_sequencer #(
   parameter int unsigned DATA_WIDTH = 13,
   parameter int unsigned TAPS       = 8,
   parameter int unsigned OUT_SHIFT  = 12
) (
   input  logic                          CLK,
   input  logic                          RST_n,
   input  logic                          VIN,
   input  logic [DATA_WIDTH-1:0]         DIN,
   output logic                          RDY,
   input  logic                          COEF_WE,
   input  logic [$clog2(TAPS+1)-1:0]     COEF_ADDR,
   input  logic [DATA_WIDTH-1:0]         COEF_DATA,
   output logic                          VOUT,
   output logic [DATA_WIDTH-1:0]         DOUT,
   output logic                          BUSY
);

   localparam int unsigned NTaps     = TAPS + 1;
   localparam int unsigned AW        = $clog2(NTaps);
   localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
   localparam int unsigned AccWidth  = ProdWidth + AW;
   localparam logic [AW-1:0] LastTap = AW'(TAPS);

   typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

   // Low-pass set loaded at reset; taps beyond the default set start at zero.
   function automatic logic [DATA_WIDTH-1:0] default_coef(input int idx);
      int v;
      case (idx)
         0, 8:    v = -26;
         1, 7:    v = -56;
         2, 6:    v = 209;
         3, 5:    v = 1088;
         4:       v = 1661;
         default: v = 0;
      endcase
      return DATA_WIDTH'(v);
   endfunction

   state_e                       state_q, state_d;
   logic [AW-1:0]                k_q, k_d;
   logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
   logic signed [AccWidth-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]        dout_q, dout_d;
   logic [DATA_WIDTH-1:0]        dline_q [NTaps];
   logic [DATA_WIDTH-1:0]        dline_d [NTaps];
   logic [DATA_WIDTH-1:0]        coef_q  [NTaps];
   logic [DATA_WIDTH-1:0]        coef_d  [NTaps];

   logic                         accept;
   logic [AW-1:0]                rd_idx;
   logic signed [ProdWidth-1:0]  prod;
   logic signed [AccWidth-1:0]   acc_sum;
   logic signed [AccWidth-1:0]   acc_shr;
   logic [DATA_WIDTH-1:0]        dout_narrow;

   assign RDY    = (state_q != StMac);
   assign BUSY   = (state_q == StMac);
   assign VOUT   = (state_q == StDone);
   assign DOUT   = dout_q;
   assign accept = VIN & RDY;

   // Explicit modulo wrap: TAPS+1 is not required to be a power of two.
   always_comb begin
      if (wr_ptr_q >= k_q) begin
         rd_idx = wr_ptr_q - k_q;
      end else begin
         rd_idx = wr_ptr_q + AW'(NTaps) - k_q;
      end
   end

   assign prod    = $signed(coef_q[k_q]) * $signed(dline_q[rd_idx]);
   assign acc_sum = acc_q + {{(AccWidth-ProdWidth){prod[ProdWidth-1]}}, prod};
   assign acc_shr = acc_sum >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
   localparam logic signed [AccWidth-1:0] OutMax =
      {{(AccWidth-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AccWidth-1:0] OutMin = ~OutMax;

   always_comb begin
      if (acc_shr > OutMax) begin
         dout_narrow = DATA_WIDTH'(OutMax);
      end else if (acc_shr < OutMin) begin
         dout_narrow = DATA_WIDTH'(OutMin);
      end else begin
         dout_narrow = DATA_WIDTH'(acc_shr);
      end
   end
`else
   assign dout_narrow = DATA_WIDTH'(acc_shr);
`endif

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      wr_ptr_d = wr_ptr_q;
      acc_d    = acc_q;
      dout_d   = dout_q;
      dline_d  = dline_q;
      coef_d   = coef_q;

      case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               dline_d[wr_ptr_q] = DIN;
               acc_d             = '0;
               k_d               = '0;
               state_d           = StMac;
            end else begin
               state_d = StIdle;
            end
         end
         StMac: begin
            acc_d = acc_sum;
            if (k_q == LastTap) begin
               dout_d   = dout_narrow;
               wr_ptr_d = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
               state_d  = StDone;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A write alongside an accept lands before the MAC reads it, so it covers that sample.
      if (COEF_WE && RDY && (COEF_ADDR <= LastTap)) begin
         coef_d[COEF_ADDR] = COEF_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_q  <= StIdle;
         k_q      <= '0;
         wr_ptr_q <= '0;
         acc_q    <= '0;
         dout_q   <= '0;
         for (int i = 0; i < NTaps; i++) begin
            dline_q[i] <= '0;
            coef_q[i]  <= default_coef(i);
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         wr_ptr_q <= wr_ptr_d;
         acc_q    <= acc_d;
         dout_q   <= dout_d;
         dline_q  <= dline_d;
         coef_q   <= coef_d;
      end
   end

endmodule
